// File: rtl/seq_alu.sv
// Registered ALU with flags and an iterative shift-add multiplier behind a start/busy/done handshake.
// Single-cycle ops complete in 1 cycle; MUL takes WIDTH cycles with busy high; start is ignored while busy.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_XOR = 4'd2, OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4, OP_CMP = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8, OP_SHR = 4'd9, OP_SRA = 4'd10, OP_MUL = 4'd11;

    // Flag bit positions within {C,L,F,Z,N}
    localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_mul_a;
    logic [2*WIDTH-1:0] r_prod;
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_result, r_result_hi;
    logic [4:0]         r_flags;
    logic               r_done;

    logic               w_accept, w_mul_last, w_slt;
    logic [WIDTH:0]     w_sum, w_diff, w_step;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_res, w_res_hi;
    logic [4:0]         w_flg;

    assign w_accept   = start && (r_state == S_IDLE);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));

    // Product register starts as {0, b}; each step adds a into the top half and shifts right.
    assign w_step     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mul_a} : '0);
    assign w_prod_nxt = {w_step, r_prod[WIDTH-1:1]};

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_slt  = $signed(a) < $signed(b);
    assign w_sh   = b[SHW-1:0];

    always_comb begin
        w_res    = r_result;
        w_res_hi = '0;
        w_flg    = r_flags;
        case (op)
            OP_AND: begin w_res = a & b; w_flg[FZ] = ~|(a & b); end
            OP_OR:  begin w_res = a | b; w_flg[FZ] = ~|(a | b); end
            OP_XOR: begin w_res = a ^ b; w_flg[FZ] = ~|(a ^ b); end
            OP_ADD: begin
                w_res     = w_sum[WIDTH-1:0];
                w_flg[FC] = w_sum[WIDTH];
                w_flg[FF] = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                w_flg[FZ] = ~|w_sum[WIDTH-1:0];
            end
            OP_SUB, OP_CMP: begin
                if (op == OP_SUB) w_res = w_diff[WIDTH-1:0];
                else              w_res_hi = r_result_hi;
                w_flg[FC] = w_diff[WIDTH];
                w_flg[FL] = w_diff[WIDTH];
                w_flg[FN] = w_slt;
                w_flg[FF] = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
                w_flg[FZ] = (a == b);
            end
            OP_SLT:  begin w_res = {{(WIDTH-1){1'b0}}, w_slt};         w_flg[FZ] = ~w_slt; end
            OP_SLTU: begin w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]}; w_flg[FZ] = ~w_diff[WIDTH]; end
            OP_SHL:  begin w_res = a << w_sh;            w_flg[FZ] = ~|(a << w_sh); end
            OP_SHR:  begin w_res = a >> w_sh;            w_flg[FZ] = ~|(a >> w_sh); end
            OP_SRA:  begin w_res = $signed(a) >>> w_sh;  w_flg[FZ] = ~|($signed(a) >>> w_sh); end
            OP_MUL:  ;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && op == OP_MUL) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_MUL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_a     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (op == OP_MUL) begin
                    r_mul_a <= a;
                    r_prod  <= {{WIDTH{1'b0}}, b};
                    r_cnt   <= '0;
                end else begin
                    r_result    <= w_res;
                    r_result_hi <= w_res_hi;
                    r_flags     <= w_flg;
                    r_done      <= 1'b1;
                end
            end else if (r_state == S_MUL) begin
                r_prod <= w_prod_nxt;
                r_cnt  <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_result    <= w_prod_nxt[WIDTH-1:0];
                    r_result_hi <= w_prod_nxt[2*WIDTH-1:WIDTH];
                    r_flags[FC] <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                    r_flags[FZ] <= ~|w_prod_nxt;
                    r_done      <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes hand-computed {result, result_hi, flags},
// a negedge monitor pops one entry per done pulse and compares.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [15:0] a = 16'd0, b = 16'd0;
    logic        busy, done;
    logic [15:0] result, result_hi;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] sb_q[$];

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_done: got result=%h hi=%h flags=%b with nothing expected",
                         result, result_hi, flags);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                if ({result, result_hi, flags} !== e) begin
                    n_err++;
                    $display("FAIL done_value: got res=%h hi=%h flg=%b expected res=%h hi=%h flg=%b",
                             result, result_hi, flags, e[36:21], e[20:5], e[4:0]);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input bit push, input logic [15:0] er, input logic [15:0] eh,
                         input logic [4:0] ef);
        start = 1'b1; op = o; a = x; b = y;
        if (push) sb_q.push_back({er, eh, ef});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            @(negedge clk);
            if (busy === 1'b1) cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {2'b0, busy, done, result, result_hi, flags[3:0]}, 40'd0);
        chk("reset_flags", {35'd0, flags}, 40'd0);

        // 1: ADD signed overflow
        issue(4'd3, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 5'b00100);
        @(negedge clk);
        chk("add_done_nobusy", {38'd0, done, busy}, 40'b10);

        // 2: SUB then CMP
        issue(4'd4, 16'h0003, 16'h0005, 1, 16'hFFFE, 16'h0000, 5'b11001);
        issue(4'd5, 16'h1234, 16'h1234, 1, 16'hFFFE, 16'h0000, 5'b00010);
        @(negedge clk);

        // 3: MUL FFFF*FFFF with an ignored ADD start at cycle 5
        issue(4'd11, 16'hFFFF, 16'hFFFF, 1, 16'h0001, 16'hFFFE, 5'b10000);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cyc++;
                if (cyc == 5) begin start = 1'b1; op = 4'd3; a = 16'd1; b = 16'd1; end
                if (cyc == 6) start = 1'b0;
            end
        end
        chk("mul_busy_cycles", 40'(cyc), 40'd16);
        chk("mul_done_at_end", {39'd0, done}, 40'd1);
        issue(4'd5, 16'h0005, 16'h0003, 1, 16'h0001, 16'hFFFE, 5'b00000);

        // 4: shifts (hi cleared) and logic/compare ops
        issue(4'd10, 16'h8000, 16'h0013, 1, 16'hF000, 16'h0000, 5'b00000);
        issue(4'd8,  16'h0001, 16'h000F, 1, 16'h8000, 16'h0000, 5'b00000);
        issue(4'd9,  16'h8000, 16'h0010, 1, 16'h8000, 16'h0000, 5'b00000);
        issue(4'd2,  16'h5555, 16'h5555, 1, 16'h0000, 16'h0000, 5'b00010);
        issue(4'd6,  16'hFFFF, 16'h0001, 1, 16'h0001, 16'h0000, 5'b00000);
        issue(4'd7,  16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0000, 5'b00010);
        issue(4'd0,  16'hF0F0, 16'h0FF0, 1, 16'h00F0, 16'h0000, 5'b00000);
        issue(4'd1,  16'h1200, 16'h0034, 1, 16'h1234, 16'h0000, 5'b00000);
        issue(4'd4,  16'h8000, 16'h0001, 1, 16'h7FFF, 16'h0000, 5'b00101);
        @(negedge clk);

        // 5: reset in the middle of a MUL
        issue(4'd11, 16'h0003, 16'h0004, 0, 16'h0, 16'h0, 5'b0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_mul_reset", {2'b0, busy, done, result, result_hi, flags[3:0]}, 40'd0);
        chk("mid_mul_reset_flags", {35'd0, flags}, 40'd0);
        issue(4'd3, 16'h0002, 16'h0002, 1, 16'h0004, 16'h0000, 5'b00000);
        @(negedge clk);

        // 6: start held through MUL completion gives back-to-back done
        issue(4'd11, 16'h0102, 16'h0304, 1, 16'h0A08, 16'h0003, 5'b10000);
        start = 1'b1; op = 4'd3; a = 16'h0001; b = 16'h0001;
        sb_q.push_back({16'h0002, 16'h0000, 5'b00000});
        wait_idle(cyc);
        chk("b2b_mul_cycles", 40'(cyc), 40'd16);
        chk("b2b_done_first", {39'd0, done}, 40'd1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_done_second", {39'd0, done}, 40'd1);
        issue(4'd4,  16'h0003, 16'h0005, 1, 16'hFFFE, 16'h0000, 5'b11001);
        issue(4'd15, 16'h1234, 16'h0001, 1, 16'h0000, 16'h0000, 5'b11001);
        @(negedge clk);
        @(negedge clk);
        chk("done_drops", {39'd0, done}, 40'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 40'(sb_q.size()), 40'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
